// File: rtl/prog_loader_imem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prog_loader_imem_pkg
//  Brief    : Shared sizes, state encoding and idle word for the loader/imem.
//  Revision : 1.0
// ============================================================================
package prog_loader_imem_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [DATA_W-1:0] c_NOP     = 16'h0000;
    localparam logic [15:0]       c_MAX_LEN = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_RUN    = 3'd5
    } state_t;

    // A header is usable only if it names at least one word and fits the store.
    function automatic logic len_ok(input logic [15:0] len);
        return (len != 16'd0) && (len <= c_MAX_LEN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imem_array
//  Brief    : DEPTH x DATA_W store, synchronous write, asynchronous read.
//  Revision : 1.0
// ============================================================================
module imem_array
    import prog_loader_imem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents deliberately survive reset so a partial program stays visible.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/prog_loader_imem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prog_loader_imem
//  Brief    : Byte-stream program loader feeding an instruction store.
//  Revision : 1.0
// ============================================================================
module prog_loader_imem
    import prog_loader_imem_pkg::*;
(
    input  logic              clk_main,
    input  logic              reset,
    input  logic              start_load,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] InstructIn,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  load_count
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_rx_ready;
    logic                r_cpu_reset;
    logic                r_load_done;
    logic                r_load_err;
    logic [CNT_W-1:0]    r_load_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len_hi;
    logic [CNT_W-1:0]    r_len;
    logic [7:0]          r_data_hi;

    logic                w_xfer;
    logic [15:0]         w_len;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_we;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;

    assign w_xfer      = rx_valid & r_rx_ready;
    assign w_len       = {r_len_hi, rx_data};
    assign w_count_inc = r_load_count + CNT_W'(1);
    assign w_we        = (r_state == S_DAT_LO) && w_xfer;
    assign w_wdata     = {r_data_hi, rx_data};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start_load) w_next_state = S_LEN_HI;
            S_LEN_HI: if (w_xfer)     w_next_state = S_LEN_LO;
            S_LEN_LO: if (w_xfer)     w_next_state = len_ok(w_len) ? S_DAT_HI : S_IDLE;
            S_DAT_HI: if (w_xfer)     w_next_state = S_DAT_LO;
            S_DAT_LO: if (w_xfer)     w_next_state = (w_count_inc == r_len) ? S_RUN : S_DAT_HI;
            S_RUN:    if (start_load) w_next_state = S_LEN_HI;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rx_ready   <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_load_count <= '0;
            r_addr       <= '0;
            r_len_hi     <= '0;
            r_len        <= '0;
            r_data_hi    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cpu_reset <= (w_next_state != S_RUN);
            r_load_done <= (w_next_state == S_RUN);
            r_rx_ready  <= (w_next_state == S_LEN_HI) || (w_next_state == S_LEN_LO) ||
                           (w_next_state == S_DAT_HI) || (w_next_state == S_DAT_LO);

            case (r_state)
                S_IDLE, S_RUN: begin
                    if (start_load) begin
                        r_load_err   <= 1'b0;
                        r_load_count <= '0;
                        r_addr       <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) r_len_hi <= rx_data;
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        if (len_ok(w_len)) begin
                            r_len <= w_len[CNT_W-1:0];
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end
                end
                S_DAT_HI: begin
                    if (w_xfer) r_data_hi <= rx_data;
                end
                S_DAT_LO: begin
                    if (w_xfer) begin
                        r_addr       <= r_addr + ADDR_W'(1);
                        r_load_count <= w_count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    imem_array u_imem_array (
        .clk   (clk_main),
        .we    (w_we),
        .waddr (r_addr),
        .wdata (w_wdata),
        .raddr (PC),
        .rdata (w_rdata)
    );

    assign rx_ready   = r_rx_ready;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign load_count = r_load_count;
    assign InstructIn = (r_state == S_RUN) ? w_rdata : c_NOP;

endmodule
`default_nettype wire
